// File: rtl/adder_pkg.sv
// Shared types and defaults for the adder settle controller.
package adder_pkg;

    localparam int DEF_WIDTH         = 32;
    localparam int DEF_SETTLE_CYCLES = 4;
    localparam int CNT_W             = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } state_e;

endpackage

// File: rtl/settle_counter.sv
// Loadable 8-bit down-counter that stops at zero and reports when it is there.
module settle_counter
    import adder_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/adder_settle_ctrl.sv
// Drives registered operands to an external combinational adder, waits a fixed
// settle time, then captures and checks the result behind a valid/ready channel.
//
// state  | meaning
// IDLE   | no operation in flight, ready for operands
// SETTLE | operands applied, counting down the adder settle time
// HOLD   | result captured, waiting for the consumer
module adder_settle_ctrl
    import adder_pkg::*;
#(
    parameter int WIDTH         = DEF_WIDTH,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,

    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_cin,
    input  logic [WIDTH-1:0] add_sum,
    input  logic             add_cout,
    input  logic             add_of,

    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_of,

    output logic             busy,
    output logic             chk_err
);

    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(SETTLE_CYCLES - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] add_a_q, add_a_d;
    logic [WIDTH-1:0] add_b_q, add_b_d;
    logic             add_cin_q, add_cin_d;
    logic [WIDTH-1:0] out_sum_q, out_sum_d;
    logic             out_cout_q, out_cout_d;
    logic             out_of_q, out_of_d;
    logic             out_valid_q, out_valid_d;
    logic             chk_err_q, chk_err_d;

    logic             cnt_load;
    logic             cnt_dec;
    logic             cnt_zero;
    logic [WIDTH:0]   ref_sum;
    logic             mismatch;

    settle_counter u_settle_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (LOAD_VAL),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    // Reference is built from the registered operands so it matches what the adder saw.
    assign ref_sum  = {1'b0, add_a_q} + {1'b0, add_b_q} + {{WIDTH{1'b0}}, add_cin_q};
    assign mismatch = (ref_sum != {add_cout, add_sum});

    always_comb begin
        state_d     = state_q;
        add_a_d     = add_a_q;
        add_b_d     = add_b_q;
        add_cin_d   = add_cin_q;
        out_sum_d   = out_sum_q;
        out_cout_d  = out_cout_q;
        out_of_d    = out_of_q;
        out_valid_d = out_valid_q;
        chk_err_d   = chk_err_q;
        cnt_load    = 1'b0;
        cnt_dec     = 1'b0;
        in_ready    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
            end
            ST_SETTLE: begin
                if (cnt_zero) begin
                    out_sum_d   = add_sum;
                    out_cout_d  = add_cout;
                    out_of_d    = add_of;
                    out_valid_d = 1'b1;
                    state_d     = ST_HOLD;
                    if (mismatch) begin
                        chk_err_d = 1'b1;
                    end
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_HOLD: begin
                in_ready = out_ready;
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A transfer in HOLD overrides the return to IDLE, giving back-to-back operation.
        if (in_valid && in_ready) begin
            add_a_d   = in_a;
            add_b_d   = in_b;
            add_cin_d = in_cin;
            cnt_load  = 1'b1;
            state_d   = ST_SETTLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            add_a_q     <= '0;
            add_b_q     <= '0;
            add_cin_q   <= 1'b0;
            out_sum_q   <= '0;
            out_cout_q  <= 1'b0;
            out_of_q    <= 1'b0;
            out_valid_q <= 1'b0;
            chk_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            add_a_q     <= add_a_d;
            add_b_q     <= add_b_d;
            add_cin_q   <= add_cin_d;
            out_sum_q   <= out_sum_d;
            out_cout_q  <= out_cout_d;
            out_of_q    <= out_of_d;
            out_valid_q <= out_valid_d;
            chk_err_q   <= chk_err_d;
        end
    end

    assign add_a     = add_a_q;
    assign add_b     = add_b_q;
    assign add_cin   = add_cin_q;
    assign out_sum   = out_sum_q;
    assign out_cout  = out_cout_q;
    assign out_of    = out_of_q;
    assign out_valid = out_valid_q;
    assign chk_err   = chk_err_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_adder_settle_ctrl.sv
// Self-checking bench for adder_settle_ctrl with a behavioural adder that can be faulted.
module tb_adder_settle_ctrl;

    localparam int W  = 32;
    localparam int S4 = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic         in_valid, in_ready, in_cin;
    logic [W-1:0] in_a, in_b;
    logic [W-1:0] add_a, add_b, add_sum;
    logic         add_cin, add_cout, add_of;
    logic         out_valid, out_ready, out_cout, out_of;
    logic [W-1:0] out_sum;
    logic         busy, chk_err;
    logic         fault;

    logic         d1_in_valid, d1_in_ready, d1_in_cin;
    logic [W-1:0] d1_in_a, d1_in_b;
    logic [W-1:0] d1_add_a, d1_add_b, d1_add_sum;
    logic         d1_add_cin, d1_add_cout, d1_add_of;
    logic         d1_out_valid, d1_out_ready, d1_out_cout, d1_out_of;
    logic [W-1:0] d1_out_sum;
    logic         d1_busy, d1_chk_err;

    always_comb begin
        {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_cin};
        if (fault) add_sum[0] = 1'b0;
        add_of = (add_a[W-1] == add_b[W-1]) && (add_sum[W-1] != add_a[W-1]);
    end

    always_comb begin
        {d1_add_cout, d1_add_sum} = {1'b0, d1_add_a} + {1'b0, d1_add_b} + {{W{1'b0}}, d1_add_cin};
        d1_add_of = (d1_add_a[W-1] == d1_add_b[W-1]) && (d1_add_sum[W-1] != d1_add_a[W-1]);
    end

    adder_settle_ctrl #(.WIDTH(W), .SETTLE_CYCLES(S4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_sum(add_sum), .add_cout(add_cout), .add_of(add_of),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
        .out_cout(out_cout), .out_of(out_of), .busy(busy), .chk_err(chk_err)
    );

    adder_settle_ctrl #(.WIDTH(W), .SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(d1_in_valid), .in_ready(d1_in_ready), .in_a(d1_in_a), .in_b(d1_in_b),
        .in_cin(d1_in_cin),
        .add_a(d1_add_a), .add_b(d1_add_b), .add_cin(d1_add_cin),
        .add_sum(d1_add_sum), .add_cout(d1_add_cout), .add_of(d1_add_of),
        .out_valid(d1_out_valid), .out_ready(d1_out_ready), .out_sum(d1_out_sum),
        .out_cout(d1_out_cout), .out_of(d1_out_of), .busy(d1_busy), .chk_err(d1_chk_err)
    );

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         of_;
        logic [W-1:0] a;
    } exp_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] sum;
        logic         cout;
        int           hold;
    } vec_t;

    exp_t sb[$];
    int   n_pass = 0;
    int   n_chk  = 0;
    int   e0     = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input logic [W-1:0] esum, input logic ecout);
        exp_t e;
        int   n;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_cin   = cin;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("send_ready", in_ready, 1);
        e.sum  = esum;
        e.cout = ecout;
        e.of_  = (a[W-1] == b[W-1]) && (esum[W-1] != a[W-1]);
        e.a    = a;
        sb.push_back(e);
        @(negedge clk);
        e0       = cyc;
        in_valid = 1'b0;
        // Scribble the operand inputs; they must be ignored while no transfer occurs.
        in_a     = $urandom;
        in_b     = $urandom;
        in_cin   = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_out(input string name);
        exp_t e;
        int   n;
        n = 0;
        while (!out_valid && n < 300) begin
            @(negedge clk);
            n++;
        end
        check({name, "_valid"}, out_valid, 1);
        check({name, "_latency"}, 64'(cyc - e0), S4);
        check({name, "_sb_nonempty"}, sb.size() != 0, 1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check({name, "_sum"}, out_sum, e.sum);
            check({name, "_cout"}, out_cout, e.cout);
            check({name, "_of"}, out_of, e.of_);
            check({name, "_add_a"}, add_a, e.a);
        end
    endtask

    task automatic hold_for(input int n, input logic [W-1:0] esum, input logic ecout);
        out_ready = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("hold_valid", out_valid, 1);
            check("hold_sum", out_sum, esum);
            check("hold_cout", out_cout, ecout);
            check("hold_in_ready", in_ready, 0);
        end
    endtask

    task automatic retire();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("retire_valid", out_valid, 0);
        check("retire_busy", busy, 0);
        check("retire_in_ready", in_ready, 1);
    endtask

    vec_t vecs[5];

    initial begin
        int t1;
        vecs[0] = '{32'h7fffffff, 32'h7fffffff, 1'b0, 32'hfffffffe, 1'b0, 0};
        vecs[1] = '{32'hffffffff, 32'hffffffff, 1'b0, 32'hfffffffe, 1'b1, 10};
        vecs[2] = '{32'hffffffff, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 2};
        vecs[3] = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1};
        vecs[4] = '{32'h12345678, 32'h87654321, 1'b1, 32'h9999999a, 1'b0, 3};

        in_valid = 0; in_a = '0; in_b = '0; in_cin = 0; out_ready = 0; fault = 0;
        d1_in_valid = 0; d1_in_a = '0; d1_in_b = '0; d1_in_cin = 0; d1_out_ready = 0;

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_chk_err", chk_err, 0);
        check("rst_add_a", add_a, 0);
        check("rst_out_sum", out_sum, 0);
        check("rst_d1_in_ready", d1_in_ready, 1);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            send(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sum, vecs[i].cout);
            wait_out("vec");
            check("vec_chk_err", chk_err, 0);
            hold_for(vecs[i].hold, vecs[i].sum, vecs[i].cout);
            retire();
        end

        // Back-to-back: retire and accept on the same edge.
        send(32'h000000af, 32'h000000af, 1'b1, 32'h0000015f, 1'b0);
        wait_out("b2b1");
        out_ready = 1'b1;
        send(32'h00000123, 32'hfffff123, 1'b0, 32'hfffff246, 1'b0);
        check("b2b_out_valid_cleared", out_valid, 0);
        check("b2b_busy", busy, 1);
        wait_out("b2b2");
        @(negedge clk);
        out_ready = 1'b0;
        check("b2b_idle", busy, 0);
        check("b2b_chk_err", chk_err, 0);

        // Reset two cycles into SETTLE discards the operation.
        send(32'h11111111, 32'h22222222, 1'b0, 32'h33333333, 1'b0);
        repeat (2) @(negedge clk);
        check("mid_busy", busy, 1);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_add_a", add_a, 0);
        check("mid_rst_out_valid", out_valid, 0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("post_rst_no_valid", out_valid, 0);
        end
        send(32'h00000055, 32'h000000aa, 1'b1, 32'h00000100, 1'b0);
        wait_out("post_rst");
        retire();

        // Faulted adder: sum bit 0 stuck low.
        fault = 1'b1;
        send(32'h00000000, 32'h00000001, 1'b0, 32'h00000000, 1'b0);
        wait_out("stuck");
        check("stuck_chk_err", chk_err, 1);
        retire();
        fault = 1'b0;
        send(32'h00000005, 32'h00000006, 1'b1, 32'h0000000c, 1'b0);
        wait_out("after_stuck");
        check("sticky_chk_err", chk_err, 1);
        retire();

        // SETTLE_CYCLES=1 instance.
        d1_in_valid = 1'b1;
        d1_in_a     = 32'h000007aa;
        d1_in_b     = 32'hffffffff;
        d1_in_cin   = 1'b0;
        check("d1_in_ready", d1_in_ready, 1);
        @(negedge clk);
        t1 = cyc;
        d1_in_valid = 1'b0;
        check("d1_not_yet", d1_out_valid, 0);
        @(negedge clk);
        check("d1_valid", d1_out_valid, 1);
        check("d1_latency", 64'(cyc - t1), 1);
        check("d1_sum", d1_out_sum, 32'h000007a9);
        check("d1_cout", d1_out_cout, 1);
        check("d1_chk_err", d1_chk_err, 0);
        d1_out_ready = 1'b1;
        @(negedge clk);
        d1_out_ready = 1'b0;
        check("d1_retired", d1_out_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, %0d/%0d so far", n_pass, n_chk);
        $fatal(1);
    end

endmodule

// File: doc/adder_settle_ctrl.md
ADDER_SETTLE_CTRL -- requirements
Module: adder_settle_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, the operand/sum width of the attached adder.
REQ-002 The block SHALL have parameter SETTLE_CYCLES, default 4, the number of full clock cycles allowed for the combinational adder to settle; legal range 1..255.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, the reset; asynchronous and active-low.
REQ-005 The block SHALL have ports in_valid (input, 1), in_ready (output, 1), in_a (input, WIDTH), in_b (input, WIDTH) and in_cin (input, 1), the operand request channel.
REQ-006 The block SHALL have ports add_a (output, WIDTH), add_b (output, WIDTH) and add_cin (output, 1), the registered operands driven to the adder.
REQ-007 The block SHALL have ports add_sum (input, WIDTH), add_cout (input, 1) and add_of (input, 1), the raw adder results.
REQ-008 The block SHALL have ports out_valid (output, 1), out_ready (input, 1), out_sum (output, WIDTH), out_cout (output, 1) and out_of (output, 1), the captured result channel.
REQ-009 The block SHALL have ports busy (output, 1), high whenever state is not IDLE, and chk_err (output, 1), a sticky self-check mismatch flag.

Function
REQ-010 The FSM SHALL have three states, IDLE, SETTLE and HOLD, and an 8-bit down-counter cnt.
REQ-011 in_ready SHALL be 1 in IDLE, equal out_ready in HOLD, and be 0 in SETTLE.
REQ-012 A transfer SHALL occur at an edge where in_valid and in_ready are both 1, and that edge SHALL register in_a, in_b and in_cin into add_a, add_b and add_cin, load cnt with SETTLE_CYCLES-1, and enter SETTLE.
REQ-013 add_a, add_b and add_cin SHALL hold stable from the transfer edge until the next transfer.
REQ-014 In SETTLE, each edge SHALL decrement cnt while cnt is not 0; at the edge where cnt is 0, the block SHALL capture add_sum, add_cout and add_of into out_sum, out_cout and out_of, set out_valid, and enter HOLD.
REQ-015 Latency: for a transfer at edge E0, capture SHALL occur at edge E0+SETTLE_CYCLES, and out_valid SHALL be 1 from that edge onward.
REQ-016 In HOLD, out_valid, out_sum, out_cout and out_of SHALL be stable while out_ready is 0.
REQ-017 In HOLD with out_ready=1 and in_valid=0, the block SHALL clear out_valid and enter IDLE.
REQ-018 In HOLD with out_ready=1 and in_valid=1 (simultaneous consume and accept), the block SHALL retire the result and accept the new operands in the same edge (REQ-012), giving zero bubble.
REQ-019 Self-check: at capture, the block SHALL compute the WIDTH+1-bit reference sum add_a+add_b+add_cin internally; if it differs from {add_cout, add_sum}, chk_err SHALL set and remain set until reset.
REQ-020 add_of SHALL be captured as delivered and SHALL NOT be recomputed or checked.
REQ-021 Input values other than in_valid SHALL be ignored when no transfer occurs.

Reset
REQ-022 While rst_n is 0, the block SHALL force state to IDLE, cnt to 0, out_valid to 0, chk_err to 0, and out_sum, out_cout, out_of, add_a, add_b and add_cin to 0, so that in_ready=1 and busy=0.
REQ-023 A reset asserted during SETTLE or HOLD SHALL discard the in-flight operation with no output transfer, and the first transfer after reset release SHALL behave per REQ-012.

Structure
REQ-024 State encodings, the default WIDTH and SETTLE_CYCLES, and the cnt width SHALL be placed in a shared package, adder_pkg.
REQ-025 The block SHALL contain one sub-module, settle_counter, with load, decrement and zero-flag functions; the FSM, capture registers and self-check SHALL remain in the top.
REQ-026 The combinational adder SHALL remain external and SHALL connect only through the add_* ports.

Verification
REQ-027 Scenario: 7fffffff+7fffffff, cin=0, with the true adder -> out_valid rises exactly 4 edges after the transfer, out_sum=fffffffe, out_cout=0, chk_err=0.
REQ-028 Scenario: ffffffff+ffffffff, cin=0, with out_ready held 0 for 10 cycles -> out_sum=fffffffe and out_cout=1 held stable, in_ready=0 throughout, and a single transfer on release.
REQ-029 Scenario: back-to-back 000000af+000000af cin=1, then 00000123+fffff123 cin=0, with out_ready=1 -> results 0000015f/cout 0, then fffff246/cout 0, with a new transfer on the same edge as each retire.
REQ-030 Scenario: rst_n pulsed low 2 cycles into SETTLE -> outputs at reset values, no out_valid pulse, and the next operation is correct.
REQ-031 Scenario: adder model with sum bit 0 stuck at 0, given 00000000+00000001 -> out_sum=00000000, chk_err=1, and chk_err stays 1 across later correct operations.
REQ-032 Scenario: SETTLE_CYCLES=1, 000007aa+ffffffff -> capture 1 edge after the transfer, out_sum=000007a9, out_cout=1.
